// File: rtl/fp_unit_arbiter.sv
// fp_unit_arbiter: round-robin sharing of one FP unit among NUM_REQ requesters,
// with per-requester operand buffering and a watchdog that force-releases a hung unit.
module fp_unit_arbiter #(
    parameter int NUM_REQ        = 4,
    parameter int ID_WIDTH       = 2,
    parameter int TIMEOUT_CYCLES = 64,
    parameter int TMO_WIDTH      = 7
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [NUM_REQ-1:0]      req_start,
    input  logic [32*NUM_REQ-1:0]   req_dataa,
    input  logic [32*NUM_REQ-1:0]   req_datab,
    input  logic [3*NUM_REQ-1:0]    req_op,
    output logic [NUM_REQ-1:0]      req_done,
    output logic [31:0]             req_result,
    output logic [31:0]             fp_dataa,
    output logic [31:0]             fp_datab,
    output logic [2:0]              fp_operation,
    output logic                    fp_clk_en,
    input  logic                    fp_done,
    input  logic [31:0]             fp_result,
    output logic                    busy,
    output logic [ID_WIDTH-1:0]     grant_id,
    output logic                    timeout_err
);
    typedef enum logic [1:0] {IDLE, ISSUE, WAIT} state_t;
    state_t state, state_nxt;
    logic [31:0] slot_a [NUM_REQ];
    logic [31:0] slot_b [NUM_REQ];
    logic [2:0] slot_op [NUM_REQ];
    logic [NUM_REQ-1:0] pending, accept;
    logic [ID_WIDTH-1:0] rr_ptr, winner, cand;
    logic [TMO_WIDTH-1:0] wd;
    logic found, tmo, done_any, grant;
    assign busy = state != IDLE;
    assign fp_clk_en = state == ISSUE;
    assign tmo = state == WAIT && !fp_done && wd == TMO_WIDTH'(TIMEOUT_CYCLES - 1);
    assign done_any = busy && (fp_done || tmo);
    assign req_result = tmo ? 32'h7FC0_0000 : fp_result;
    assign grant = state == IDLE && found;
    always_comb begin
        winner = '0;
        found = 1'b0;
        cand = '0;
        for (int k = 1; k <= NUM_REQ; k++) begin
            cand = ID_WIDTH'((int'(rr_ptr) + k) % NUM_REQ);
            if (!found && pending[cand]) begin
                winner = cand;
                found = 1'b1;
            end
        end
    end
    // the in-flight request still counts as outstanding until its done cycle
    always_comb begin
        accept = '0;
        for (int i = 0; i < NUM_REQ; i++)
            accept[i] = req_start[i] && !pending[i] && !(busy && !done_any && grant_id == ID_WIDTH'(i));
    end
    always_comb begin
        req_done = '0;
        if (done_any) req_done[grant_id] = 1'b1;
    end
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    state_nxt = found ? ISSUE : IDLE;
            ISSUE:   state_nxt = fp_done ? IDLE : WAIT;
            WAIT:    state_nxt = done_any ? IDLE : WAIT;
            default: state_nxt = IDLE;
        endcase
    end
    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else state <= state_nxt;
    end
    always_ff @(posedge clk) begin
        for (int i = 0; i < NUM_REQ; i++) begin
            if (accept[i]) begin
                slot_a[i] <= req_dataa[32*i +: 32];
                slot_b[i] <= req_datab[32*i +: 32];
                slot_op[i] <= req_op[3*i +: 3];
            end
        end
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            pending <= '0;
            rr_ptr <= ID_WIDTH'(NUM_REQ - 1);
            grant_id <= '0;
            fp_dataa <= '0;
            fp_datab <= '0;
            fp_operation <= '0;
            timeout_err <= 1'b0;
            wd <= '0;
        end else begin
            pending <= (pending | accept) & ~(grant ? NUM_REQ'(1) << winner : '0);
            if (tmo || (req_start & ~accept) != '0) timeout_err <= 1'b1;
            if (grant) begin
                fp_dataa <= slot_a[winner];
                fp_datab <= slot_b[winner];
                fp_operation <= slot_op[winner];
                grant_id <= winner;
                rr_ptr <= winner;
                wd <= '0;
            end else if (busy) begin
                wd <= wd + 1'b1;
            end
        end
    end
endmodule

// File: tb/tb_fp_unit_arbiter.sv
// tb_fp_unit_arbiter: directed tests with a queue scoreboard; a stub FP unit answers
// with a + b + op after a per-requester latency (-1 = never answers).
module tb_fp_unit_arbiter;
    logic clk = 0;
    logic rst;
    logic [3:0] req_start;
    logic [127:0] req_dataa, req_datab;
    logic [11:0] req_op;
    logic [3:0] req_done;
    logic [31:0] req_result, fp_dataa, fp_datab, fp_result;
    logic [2:0] fp_operation;
    logic fp_clk_en, fp_done, busy, timeout_err;
    logic [1:0] grant_id;

    typedef struct {int id; logic [31:0] res; bit tmo;} exp_t;
    exp_t exp_q[$];
    int checks = 0, errors = 0;
    int lat_by_id[4];

    fp_unit_arbiter dut (
        .clk(clk), .rst(rst), .req_start(req_start), .req_dataa(req_dataa),
        .req_datab(req_datab), .req_op(req_op), .req_done(req_done),
        .req_result(req_result), .fp_dataa(fp_dataa), .fp_datab(fp_datab),
        .fp_operation(fp_operation), .fp_clk_en(fp_clk_en), .fp_done(fp_done),
        .fp_result(fp_result), .busy(busy), .grant_id(grant_id), .timeout_err(timeout_err)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] model(logic [31:0] a, logic [31:0] b, logic [2:0] op);
        return a + b + {29'd0, op};
    endfunction

    task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h want %h at %0t", name, act, exp, $time);
        end
    endtask

    initial begin
        int cnt;
        bit active;
        fp_done = 0;
        fp_result = 0;
        active = 0;
        cnt = 0;
        forever begin
            @(posedge clk); #1;
            fp_done = 0;
            if (fp_clk_en && lat_by_id[grant_id] >= 0) begin
                active = 1;
                cnt = lat_by_id[grant_id];
            end
            if (active) begin
                if (cnt == 0) begin
                    fp_done = 1;
                    fp_result = model(fp_dataa, fp_datab, fp_operation);
                    active = 0;
                end else cnt--;
            end
        end
    end

    always @(negedge clk) begin
        if (req_done != 0) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_done: got req_done %b want 0000 at %0t", req_done, $time);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                chk("done_vec", {28'd0, req_done}, 32'd1 << e.id);
                chk("result", req_result, e.res);
                chk("fp_done_coincident", {31'd0, fp_done}, {31'd0, !e.tmo});
            end
        end
    end

    task automatic set_op(int i, logic [31:0] a, logic [31:0] b, logic [2:0] op);
        req_dataa[32*i +: 32] = a;
        req_datab[32*i +: 32] = b;
        req_op[3*i +: 3] = op;
    endtask

    task automatic push(int id, logic [31:0] res, bit tmo);
        exp_t e;
        e.id = id;
        e.res = res;
        e.tmo = tmo;
        exp_q.push_back(e);
    endtask

    task automatic fire(logic [3:0] m);
        req_start = m;
        @(posedge clk); #1;
        req_start = 0;
    endtask

    task automatic tick(int n);
        repeat (n) begin @(posedge clk); #1; end
    endtask

    task automatic do_reset();
        rst = 1;
        tick(1);
        rst = 0;
    endtask

    task automatic drain(string name);
        int n = 0;
        while (exp_q.size() != 0 && n < 300) begin tick(1); n++; end
        chk(name, exp_q.size(), 0);
        tick(2);
    endtask

    initial begin
        int n;
        bit saw;
        rst = 1;
        req_start = 0;
        req_dataa = 0;
        req_datab = 0;
        req_op = 0;
        lat_by_id = '{2, 2, 2, 2};
        tick(3);
        rst = 0;
        chk("rst_busy", {31'd0, busy}, 0);
        chk("rst_grant_id", {30'd0, grant_id}, 0);
        chk("rst_clk_en", {31'd0, fp_clk_en}, 0);
        chk("rst_dataa", fp_dataa, 0);
        chk("rst_tmo_err", {31'd0, timeout_err}, 0);

        // T1: single request
        lat_by_id[0] = 5;
        set_op(0, 32'h3f80_0000, 32'h4000_0000, 3'd3);
        push(0, 32'h7f80_0003, 0);
        fire(4'b0001);
        chk("t1_clk_en_early", {31'd0, fp_clk_en}, 0);
        tick(1);
        chk("t1_clk_en", {31'd0, fp_clk_en}, 1);
        chk("t1_grant", {30'd0, grant_id}, 0);
        chk("t1_dataa", fp_dataa, 32'h3f80_0000);
        chk("t1_datab", fp_datab, 32'h4000_0000);
        chk("t1_op", {29'd0, fp_operation}, 3);
        tick(1);
        chk("t1_clk_en_pulse", {31'd0, fp_clk_en}, 0);
        chk("t1_busy", {31'd0, busy}, 1);
        drain("t1_drain");

        // T2: contention, fresh pointer so requester 0 wins first
        do_reset();
        lat_by_id[0] = 2;
        set_op(0, 32'h0000_1000, 32'h0000_0001, 3'd0);
        set_op(1, 32'h0000_2000, 32'h0000_0002, 3'd1);
        set_op(2, 32'h0000_3000, 32'h0000_0003, 3'd2);
        set_op(3, 32'h0000_4000, 32'h0000_0004, 3'd4);
        push(0, 32'h0000_1001, 0);
        push(1, 32'h0000_2003, 0);
        push(2, 32'h0000_3005, 0);
        push(3, 32'h0000_4008, 0);
        fire(4'b1111);
        drain("t2a_drain");
        set_op(1, 32'h1111_0000, 32'h0000_0010, 3'd1);
        set_op(3, 32'h3333_0000, 32'h0000_0030, 3'd2);
        push(1, 32'h1111_0011, 0);
        push(3, 32'h3333_0032, 0);
        fire(4'b1010);
        drain("t2b_drain");

        // T3: unit finishes in the ISSUE cycle
        lat_by_id[2] = 0;
        set_op(2, 32'h0000_0100, 32'h0000_0200, 3'd2);
        push(2, 32'h0000_0302, 0);
        fire(4'b0100);
        tick(1);
        chk("t3_busy_issue", {31'd0, busy}, 1);
        tick(1);
        chk("t3_back_idle", {31'd0, busy}, 0);
        drain("t3_drain");

        // T4: requester 3 hangs the unit, requester 1 is served afterwards
        lat_by_id[3] = -1;
        lat_by_id[1] = 3;
        set_op(1, 32'h0000_0a00, 32'h0000_0b00, 3'd1);
        set_op(3, 32'hdead_0000, 32'h0000_beef, 3'd0);
        push(3, 32'h7fc0_0000, 1);
        push(1, 32'h0000_1501, 0);
        fire(4'b1010);
        n = 0;
        while (!fp_clk_en && n < 10) begin tick(1); n++; end
        chk("t4_issue_seen", {31'd0, fp_clk_en}, 1);
        chk("t4_tmo_err_before", {31'd0, timeout_err}, 0);
        n = 0;
        while (!req_done[3] && n < 100) begin tick(1); n++; end
        chk("t4_expiry_cycle", n, 63);
        tick(1);
        chk("t4_tmo_err", {31'd0, timeout_err}, 1);
        chk("t4_released", {31'd0, busy}, 0);
        tick(1);
        chk("t4_next_grant", {30'd0, grant_id}, 1);
        chk("t4_next_clk_en", {31'd0, fp_clk_en}, 1);
        drain("t4_drain");

        // T5: requester 2 starts twice while waiting behind requester 0
        do_reset();
        lat_by_id = '{10, 2, 2, 2};
        set_op(0, 32'h0000_0005, 32'h0000_0006, 3'd1);
        push(0, 32'h0000_000c, 0);
        fire(4'b0001);
        tick(1);
        set_op(2, 32'h0001_0000, 32'h0000_0001, 3'd3);
        push(2, 32'h0001_0004, 0);
        fire(4'b0100);
        chk("t5_first_ok", {31'd0, timeout_err}, 0);
        set_op(2, 32'h0fff_0000, 32'h0fff_0000, 3'd4);
        fire(4'b0100);
        chk("t5_double", {31'd0, timeout_err}, 1);
        drain("t5_drain");

        // T6: reset during WAIT with another request pending
        lat_by_id[1] = 8;
        set_op(1, 32'h0000_0077, 32'h0000_0088, 3'd0);
        fire(4'b0010);
        tick(1);
        set_op(3, 32'h0000_0001, 32'h0000_0001, 3'd0);
        fire(4'b1000);
        tick(2);
        chk("t6_in_wait", {31'd0, busy}, 1);
        do_reset();
        chk("t6_busy", {31'd0, busy}, 0);
        chk("t6_clk_en", {31'd0, fp_clk_en}, 0);
        chk("t6_dataa", fp_dataa, 0);
        chk("t6_datab", fp_datab, 0);
        chk("t6_op", {29'd0, fp_operation}, 0);
        chk("t6_grant", {30'd0, grant_id}, 0);
        chk("t6_tmo_err", {31'd0, timeout_err}, 0);
        saw = 0;
        repeat (20) begin tick(1); if (busy) saw = 1; end
        chk("t6_pending_dropped", {31'd0, saw}, 0);
        chk("t6_no_expected_left", exp_q.size(), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL global_timeout: simulation did not finish, errors %0d", errors);
        $fatal(1, "timeout");
    end
endmodule
